// File: rtl/quadrature_angle_decoder.sv
// Quadrature encoder front end for the steering angle loop.
// Synchronises and glitch-filters A/B/index, decodes 4x into a wrapping
// position count, and reports direction, illegal transitions and stall.
module quadrature_angle_decoder #(
    parameter int CPR          = 4096,
    parameter int FILTER_LEN   = 4,
    parameter int STALL_CYCLES = 50000,
    parameter bit INDEX_ENABLE = 1'b1,
    parameter bit INVERT_DIR   = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        enc_index,
    input  logic        zero_req,
    input  logic        clear_error,
    output logic [11:0] current_angle,
    output logic        angle_valid,
    output logic        direction,
    output logic        step,
    output logic        quad_error,
    output logic        stalled
);

    localparam logic [11:0] MAX_COUNT = 12'(CPR - 1);
    localparam logic [3:0]  FILT_LEN  = 4'(FILTER_LEN);
    localparam logic [19:0] STALL_MAX = 20'(STALL_CYCLES);

    // Pin bit order used throughout: [2] = index, [1] = A, [0] = B.
    logic [2:0]  sync1_q, sync2_q;
    logic [2:0]  filt_q, filt_d;
    logic [2:0]  filt_prev_q;
    logic [3:0]  filt_cnt_q [3];
    logic [3:0]  filt_cnt_d [3];

    logic [11:0] count_q, count_d;
    logic        valid_q, valid_d;
    logic        dir_q, dir_d;
    logic        step_q, step_d;
    logic        err_q, err_d;
    logic [19:0] stall_cnt_q, stall_cnt_d;
    logic        stalled_q, stalled_d;

    logic [1:0]  pos_old, pos_new, pos_diff;
    logic        fwd_raw, rev_raw, illegal;
    logic        inc, dec, index_rise;

    // Two-flop synchroniser on the asynchronous encoder pins.
    always_ff @(posedge clock) begin
        sync1_q <= {enc_index, enc_a, enc_b};
        sync2_q <= sync1_q;
    end

    // Per-pin filter: accept a new level only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 3; i++) begin
            filt_cnt_d[i] = 4'd0;
            if (sync2_q[i] != filt_q[i]) begin
                if (filt_cnt_q[i] + 4'd1 == FILT_LEN) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    filt_cnt_d[i] = filt_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Filter state; at reset the filter tracks the synchroniser so release causes no event.
    always_ff @(posedge clock) begin
        if (reset) begin
            filt_q      <= sync2_q;
            filt_prev_q <= sync2_q;
            for (int i = 0; i < 3; i++) filt_cnt_q[i] <= 4'd0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 3; i++) filt_cnt_q[i] <= filt_cnt_d[i];
        end
    end

    // 4x decode and next-state for count, flags and stall supervision.
    always_comb begin
        // Gray {A,B} -> quadrant position, so a legal step is a difference of +/-1 mod 4.
        pos_old  = {filt_prev_q[1], filt_prev_q[1] ^ filt_prev_q[0]};
        pos_new  = {filt_q[1], filt_q[1] ^ filt_q[0]};
        pos_diff = pos_new - pos_old;
        fwd_raw  = (pos_diff == 2'd1);
        rev_raw  = (pos_diff == 2'd3);
        illegal  = (pos_diff == 2'd2);
        inc      = INVERT_DIR ? rev_raw : fwd_raw;
        dec      = INVERT_DIR ? fwd_raw : rev_raw;
        step_d   = fwd_raw | rev_raw;
        index_rise = INDEX_ENABLE && filt_q[2] && !filt_prev_q[2];

        count_d = count_q;
        if (inc) begin
            count_d = (count_q == MAX_COUNT) ? 12'd0 : count_q + 12'd1;
        end else if (dec) begin
            count_d = (count_q == 12'd0) ? MAX_COUNT : count_q - 12'd1;
        end
        // Referencing overrides the step's count effect but not step/direction.
        if (zero_req || index_rise) begin
            count_d = 12'd0;
        end

        dir_d   = step_d ? inc : dir_q;
        valid_d = valid_q | zero_req | index_rise | !INDEX_ENABLE;
        err_d   = illegal ? 1'b1 : (clear_error ? 1'b0 : err_q);

        if (step_d) begin
            stall_cnt_d = 20'd0;
        end else if (stall_cnt_q == STALL_MAX) begin
            stall_cnt_d = stall_cnt_q;
        end else begin
            stall_cnt_d = stall_cnt_q + 20'd1;
        end
        // Compared against the pre-step count so stalled falls one cycle after step.
        stalled_d = (stall_cnt_q == STALL_MAX);
    end

    // Registered outputs and supervision state.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= 12'd0;
            valid_q     <= 1'b0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
            stall_cnt_q <= 20'd0;
            stalled_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            valid_q     <= valid_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            stalled_q   <= stalled_d;
        end
    end

    assign current_angle = count_q;
    assign angle_valid   = valid_q;
    assign direction     = dir_q;
    assign step          = step_q;
    assign quad_error    = err_q;
    assign stalled       = stalled_q;

endmodule

// File: tb/tb_quadrature_angle_decoder.sv
// Bench for quadrature_angle_decoder: directed tables, corner sequences
// and random moves against a modular-arithmetic position model.
module tb_quadrature_angle_decoder;

    logic        clock = 1'b0;
    logic        reset, enc_a, enc_b, enc_index, zero_req, clear_error;
    logic [11:0] current_angle, angle2;
    logic        angle_valid, direction, step, quad_error, stalled;
    logic        valid2, dir2, step2, err2, stalled2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int step_seen = 0;
    int last_step_cyc = -1;
    int ph = 0;

    always #5 clock = ~clock;

    quadrature_angle_decoder #(
        .CPR(4096), .FILTER_LEN(4), .STALL_CYCLES(100),
        .INDEX_ENABLE(1'b1), .INVERT_DIR(1'b0)
    ) dut (
        .clock(clock), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .enc_index(enc_index), .zero_req(zero_req), .clear_error(clear_error),
        .current_angle(current_angle), .angle_valid(angle_valid),
        .direction(direction), .step(step), .quad_error(quad_error),
        .stalled(stalled)
    );

    quadrature_angle_decoder #(
        .CPR(400), .FILTER_LEN(4), .STALL_CYCLES(100),
        .INDEX_ENABLE(1'b1), .INVERT_DIR(1'b0)
    ) dut2 (
        .clock(clock), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .enc_index(enc_index), .zero_req(zero_req), .clear_error(clear_error),
        .current_angle(angle2), .angle_valid(valid2),
        .direction(dir2), .step(step2), .quad_error(err2),
        .stalled(stalled2)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (step === 1'b1) begin
            step_seen++;
            last_step_cyc = cyc;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Quadrant 0..3 maps to {A,B} = 00, 01, 11, 10.
    task automatic set_ph(input int p);
        ph    = ((p % 4) + 4) % 4;
        enc_a = (ph >= 2);
        enc_b = (ph == 1 || ph == 2);
    endtask

    typedef struct {
        int kind;       // 0 fwd, 1 rev, 2 glitch A, 3 glitch B, 4 double, 5 clear, 6 double+clear
        int exp_angle;
        int exp_angle2;
        int exp_dir;
        int exp_err;
        int exp_steps;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, t0, m1, m2, mdir, op, es, len;

        tbl[0]  = '{0,    1,   1, 1, 0, 1};
        tbl[1]  = '{0,    2,   2, 1, 0, 1};
        tbl[2]  = '{1,    1,   1, 0, 0, 1};
        tbl[3]  = '{2,    1,   1, 0, 0, 0};
        tbl[4]  = '{3,    1,   1, 0, 0, 0};
        tbl[5]  = '{4,    1,   1, 0, 1, 0};
        tbl[6]  = '{1,    0,   0, 0, 1, 1};
        tbl[7]  = '{5,    0,   0, 0, 0, 0};
        tbl[8]  = '{1, 4095, 399, 0, 0, 1};
        tbl[9]  = '{6, 4095, 399, 0, 1, 0};
        tbl[10] = '{5, 4095, 399, 0, 0, 0};
        tbl[11] = '{0,    0,   0, 1, 0, 1};

        // Reset with A=B=1 held
        reset = 1'b1; enc_index = 1'b0; zero_req = 1'b0; clear_error = 1'b0;
        set_ph(2);
        ticks(4);
        check("rst_angle", 32'(current_angle), 0);
        check("rst_valid", 32'(angle_valid), 0);
        check("rst_dir", 32'(direction), 0);
        check("rst_step", 32'(step), 0);
        check("rst_err", 32'(quad_error), 0);
        check("rst_stalled", 32'(stalled), 0);
        reset = 1'b0;
        s0 = step_seen;
        ticks(10);
        check("rel_steps", step_seen - s0, 0);
        check("rel_err", 32'(quad_error), 0);
        check("rel_angle", 32'(current_angle), 0);
        check("rel_valid", 32'(angle_valid), 0);

        // 12 forward edges, 40 cycles apart, each step 7 cycles after the pin edge
        for (int e = 0; e < 12; e++) begin
            set_ph(ph + 1);
            t0 = cyc;
            s0 = step_seen;
            ticks(40);
            check("fwd12_steps", step_seen - s0, 1);
            check("fwd12_latency", last_step_cyc - t0, 7);
        end
        check("fwd12_angle", 32'(current_angle), 12);
        check("fwd12_dir", 32'(direction), 1);

        // Advance to 250, then index zeroes and references the count
        for (int e = 0; e < 238; e++) begin
            set_ph(ph + 1);
            ticks(10);
        end
        check("pre_idx_angle", 32'(current_angle), 250);
        check("pre_idx_angle2", 32'(angle2), 250);
        check("pre_idx_valid", 32'(angle_valid), 0);
        enc_index = 1'b1;
        s0 = step_seen;
        ticks(10);
        check("idx_angle", 32'(current_angle), 0);
        check("idx_angle2", 32'(angle2), 0);
        check("idx_valid", 32'(angle_valid), 1);
        check("idx_no_step", step_seen - s0, 0);
        enc_index = 1'b0;
        ticks(10);
        check("idx_fall_angle", 32'(current_angle), 0);

        // Wrap both ways, CPR=4096 and CPR=400
        set_ph(ph + 3);
        ticks(12);
        check("wrap_rev", 32'(current_angle), 4095);
        check("wrap_rev_cpr400", 32'(angle2), 399);
        set_ph(ph + 1);
        ticks(12);
        check("wrap_fwd", 32'(current_angle), 0);
        check("wrap_fwd_cpr400", 32'(angle2), 0);

        // Table of moves, glitches and error handling
        for (int k = 0; k < 12; k++) begin
            s0 = step_seen;
            case (tbl[k].kind)
                0: begin set_ph(ph + 1); ticks(15); end
                1: begin set_ph(ph + 3); ticks(15); end
                2: begin enc_a = ~enc_a; ticks(3); enc_a = ~enc_a; ticks(15); end
                3: begin enc_b = ~enc_b; ticks(3); enc_b = ~enc_b; ticks(15); end
                4: begin set_ph(ph + 2); ticks(15); end
                5: begin clear_error = 1'b1; tick(); clear_error = 1'b0; ticks(3); end
                default: begin
                    set_ph(ph + 2);
                    ticks(6);
                    clear_error = 1'b1;
                    tick();
                    clear_error = 1'b0;
                    ticks(8);
                end
            endcase
            check($sformatf("tbl%0d_angle", k), 32'(current_angle), tbl[k].exp_angle);
            check($sformatf("tbl%0d_angle2", k), 32'(angle2), tbl[k].exp_angle2);
            check($sformatf("tbl%0d_dir", k), 32'(direction), tbl[k].exp_dir);
            check($sformatf("tbl%0d_err", k), 32'(quad_error), tbl[k].exp_err);
            check($sformatf("tbl%0d_steps", k), step_seen - s0, tbl[k].exp_steps);
        end

        // zero_req coincident with a forward step
        set_ph(ph + 3); ticks(12);
        set_ph(ph + 3); ticks(12);
        check("zr_pre_angle", 32'(current_angle), 4094);
        check("zr_pre_angle2", 32'(angle2), 398);
        check("zr_pre_dir", 32'(direction), 0);
        set_ph(ph + 1);
        ticks(6);
        zero_req = 1'b1;
        tick();
        zero_req = 1'b0;
        check("zr_step", 32'(step), 1);
        check("zr_dir", 32'(direction), 1);
        check("zr_angle", 32'(current_angle), 0);
        check("zr_angle2", 32'(angle2), 0);
        ticks(10);
        check("zr_hold_angle", 32'(current_angle), 0);

        // Random moves against a modular position model
        m1 = 0; m2 = 0; mdir = 1;
        for (int r = 0; r < 200; r++) begin
            op = int'($urandom_range(0, 4));
            s0 = step_seen;
            es = 0;
            case (op)
                0: begin set_ph(ph + 1); m1 = (m1 + 1) % 4096; m2 = (m2 + 1) % 400; mdir = 1; es = 1; end
                1: begin set_ph(ph + 3); m1 = (m1 + 4095) % 4096; m2 = (m2 + 399) % 400; mdir = 0; es = 1; end
                2: begin
                    len = int'($urandom_range(1, 3));
                    if ($urandom_range(0, 1) == 0) begin
                        enc_a = ~enc_a; ticks(len); enc_a = ~enc_a;
                    end else begin
                        enc_b = ~enc_b; ticks(len); enc_b = ~enc_b;
                    end
                end
                3: ;
                default: begin zero_req = 1'b1; tick(); zero_req = 1'b0; m1 = 0; m2 = 0; end
            endcase
            ticks(int'($urandom_range(10, 20)));
            check("rnd_angle", 32'(current_angle), m1);
            check("rnd_angle2", 32'(angle2), m2);
            check("rnd_dir", 32'(direction), mdir);
            check("rnd_steps", step_seen - s0, es);
            check("rnd_err", 32'(quad_error), 0);
        end

        // Stall detection, release on a step, and reset mid-stall
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("st_rst_angle", 32'(current_angle), 0);
        check("st_rst_valid", 32'(angle_valid), 0);
        s0 = step_seen;
        ticks(100);
        check("st_c100", 32'(stalled), 0);
        check("st_no_steps", step_seen - s0, 0);
        tick();
        check("st_c101", 32'(stalled), 1);
        set_ph(ph + 1);
        ticks(7);
        check("st_step", 32'(step), 1);
        check("st_step_cycle_stalled", 32'(stalled), 1);
        tick();
        check("st_after_step", 32'(stalled), 0);
        ticks(110);
        check("st_again", 32'(stalled), 1);
        reset = 1'b1;
        tick();
        check("st_mid_reset", 32'(stalled), 0);
        reset = 1'b0;
        ticks(100);
        check("st_cnt_cleared", 32'(stalled), 0);
        tick();
        check("st_restall", 32'(stalled), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
